ex_commit_buffer: RTL and testbench

//  Parametrised writeback commit stage between the NCH execution units and the register file.

---
 rtl/ex_commit_buffer_if.sv | 57 +++++
 rtl/ex_commit_buffer.sv | 174 +++++++++++++++++
 tb/tb_ex_commit_buffer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_commit_buffer_if.sv
// ---------------------------------------------------------------------------
// ex_commit_buffer_if
//   Bundles the result-side handshake, the commit gate and the registered
//   writeback bus of ex_commit_buffer. Clock and reset stay outside.
//
//   Handshake (per channel i): a result moves into the buffer on a rising
//   edge where in_valid[i] && in_ready[i] are both high (and flush is low).
//   in_ready depends only on registered occupancy, never on in_valid. A
//   producer may hold in_valid high while in_ready is low and must keep
//   in_data/in_addr/in_pc/in_ena stable until the transfer happens.
//
//   Signals
//     commit_pc  scoreboard commit point (entry eligible when pc <= commit_pc)
//     flush      discard all buffered results
//     in_*       per-channel result inputs, channel i at [i*W +: W]
//     in_ready   per-channel FIFO not full
//     wb_*       registered writeback outputs, wb_retire pulses per retirement
//     occupancy  per-channel entry count, ($clog2(DEPTH)+1) bits per channel
//
//   Modports
//     master  producer / scoreboard / register-file side
//     slave   ex_commit_buffer
// ---------------------------------------------------------------------------
interface ex_commit_buffer_if #(
  parameter int NCH   = 3,
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int PCW   = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PCW-1:0]      commit_pc;
  logic                flush;
  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [NCH*XLEN-1:0] in_data;
  logic [NCH*AW-1:0]   in_addr;
  logic [NCH*PCW-1:0]  in_pc;
  logic [NCH-1:0]      in_ena;
  logic [NCH*XLEN-1:0] wb_data;
  logic [NCH*AW-1:0]   wb_addr;
  logic [NCH-1:0]      wb_ena;
  logic [NCH*PCW-1:0]  wb_pc;
  logic [NCH-1:0]      wb_retire;
  logic [NCH*CW-1:0]   occupancy;

  modport master (
    output commit_pc, flush, in_valid, in_data, in_addr, in_pc, in_ena,
    input  in_ready, wb_data, wb_addr, wb_ena, wb_pc, wb_retire, occupancy
  );

  modport slave (
    input  commit_pc, flush, in_valid, in_data, in_addr, in_pc, in_ena,
    output in_ready, wb_data, wb_addr, wb_ena, wb_pc, wb_retire, occupancy
  );
endinterface

// File: rtl/ex_commit_buffer.sv
// ---------------------------------------------------------------------------
// ex_commit_buffer
//   Writeback commit stage between NCH execution channels and the register
//   file. Each channel keeps a DEPTH-entry FIFO of completed results
//   (data, rd, pc, wen). The head entry retires to the registered wb_*
//   outputs only when its pc <= commit_pc (unsigned); younger results wait
//   and are never dropped. flush discards everything buffered.
//
//   Ports
//     clk   clock
//     rst   synchronous, active-high reset (acts as flush and also clears
//           wb_data / wb_addr / wb_pc)
//     bus   ex_commit_buffer_if.slave: commit_pc, flush, in_* handshake,
//           wb_* writeback, occupancy
//
//   Optional feature (macro EX_COMMIT_BYPASS_EN)
//     Defined: a result arriving at an empty channel whose pc is already
//     committed goes straight to wb_* on the accepting edge (1-edge latency)
//     and is not written into the FIFO. Suppressed while flush is high.
//     Undefined: every result passes through the FIFO (2-edge minimum).
//
//   No FSM: per-channel state is just head/tail/count, exposed via occupancy.
// ---------------------------------------------------------------------------
module ex_commit_buffer #(
  parameter int NCH   = 3,
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int PCW   = 64,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  ex_commit_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage; contents need no reset, validity is tracked by count.
  logic [XLEN-1:0] mem_data [NCH][DEPTH];
  logic [AW-1:0]   mem_addr [NCH][DEPTH];
  logic [PCW-1:0]  mem_pc   [NCH][DEPTH];
  logic            mem_ena  [NCH][DEPTH];

  logic [PW-1:0]   head  [NCH];
  logic [PW-1:0]   tail  [NCH];
  logic [CW-1:0]   count [NCH];

  // Registered writeback state.
  logic [XLEN-1:0] wb_data_q [NCH];
  logic [AW-1:0]   wb_addr_q [NCH];
  logic [PCW-1:0]  wb_pc_q   [NCH];
  logic [NCH-1:0]  wb_ena_q;
  logic [NCH-1:0]  wb_retire_q;

  // Unpacked views of the per-channel input fields.
  logic [XLEN-1:0] ch_data [NCH];
  logic [AW-1:0]   ch_addr [NCH];
  logic [PCW-1:0]  ch_pc   [NCH];
  logic [NCH-1:0]  ch_ena;

  logic [NCH-1:0]  ready;
  logic [NCH-1:0]  accept;   // handshake completes on this edge
  logic [NCH-1:0]  bypass;   // accepted entry goes straight to wb_*
  logic [NCH-1:0]  push;     // accepted entry is written into the FIFO
  logic [NCH-1:0]  pop;      // FIFO head retires on this edge

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_data[i] = bus.in_data[i*XLEN +: XLEN];
      ch_addr[i] = bus.in_addr[i*AW +: AW];
      ch_pc[i]   = bus.in_pc[i*PCW +: PCW];
      ch_ena[i]  = bus.in_ena[i];

      // Registered count only: a full FIFO cannot take a new entry on the
      // same edge its head retires.
      ready[i]  = (count[i] != CW'(DEPTH));
      accept[i] = bus.in_valid[i] && ready[i] && !bus.flush;
      pop[i]    = (count[i] != '0) && (mem_pc[i][head[i]] <= bus.commit_pc);
`ifdef EX_COMMIT_BYPASS_EN
      bypass[i] = accept[i] && (count[i] == '0) && (ch_pc[i] <= bus.commit_pc);
`else
      bypass[i] = 1'b0;
`endif
      push[i]   = accept[i] && !bypass[i];
    end
  end

  // FIFO write port. push already excludes flush edges.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) begin
        mem_data[i][tail[i]] <= ch_data[i];
        mem_addr[i][tail[i]] <= ch_addr[i];
        mem_pc[i][tail[i]]   <= ch_pc[i];
        mem_ena[i][tail[i]]  <= ch_ena[i];
      end
    end
  end

  // Pointers, counts and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        head[i]      <= '0;
        tail[i]      <= '0;
        count[i]     <= '0;
        wb_data_q[i] <= '0;
        wb_addr_q[i] <= '0;
        wb_pc_q[i]   <= '0;
      end
      wb_ena_q    <= '0;
      wb_retire_q <= '0;
    end else if (bus.flush) begin
      // Flush wins over accept and retire; wb_data/addr/pc keep their values.
      for (int i = 0; i < NCH; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      wb_ena_q    <= '0;
      wb_retire_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) tail[i] <= tail[i] + PW'(1);
        if (pop[i])  head[i] <= head[i] + PW'(1);

        // Simultaneous push and pop leaves count unchanged.
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CW'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CW'(1);
        end

        // pop and bypass are exclusive: bypass needs an empty FIFO.
        if (pop[i]) begin
          wb_data_q[i]   <= mem_data[i][head[i]];
          wb_addr_q[i]   <= mem_addr[i][head[i]];
          wb_pc_q[i]     <= mem_pc[i][head[i]];
          // x0 is architecturally zero: retire it but never write it.
          wb_ena_q[i]    <= mem_ena[i][head[i]] && (mem_addr[i][head[i]] != '0);
          wb_retire_q[i] <= 1'b1;
        end else if (bypass[i]) begin
          wb_data_q[i]   <= ch_data[i];
          wb_addr_q[i]   <= ch_addr[i];
          wb_pc_q[i]     <= ch_pc[i];
          wb_ena_q[i]    <= ch_ena[i] && (ch_addr[i] != '0);
          wb_retire_q[i] <= 1'b1;
        end else begin
          wb_ena_q[i]    <= 1'b0;
          wb_retire_q[i] <= 1'b0;
        end
      end
    end
  end

  // Pack per-channel state onto the interface vectors.
  always_comb begin
    bus.in_ready  = ready;
    bus.wb_ena    = wb_ena_q;
    bus.wb_retire = wb_retire_q;
    bus.wb_data   = '0;
    bus.wb_addr   = '0;
    bus.wb_pc     = '0;
    bus.occupancy = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.wb_data[i*XLEN +: XLEN] = wb_data_q[i];
      bus.wb_addr[i*AW +: AW]     = wb_addr_q[i];
      bus.wb_pc[i*PCW +: PCW]     = wb_pc_q[i];
      bus.occupancy[i*CW +: CW]   = count[i];
    end
  end

endmodule

// File: tb/tb_ex_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_ex_commit_buffer
//   Directed bench for ex_commit_buffer with default parameters
//   (NCH=3, XLEN=64, AW=5, PCW=64, DEPTH=4). Inputs change 1 time unit after
//   each rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_ex_commit_buffer;

`ifdef EX_COMMIT_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  ex_commit_buffer_if bus ();

  ex_commit_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int ch, input logic [63:0] pc, input logic [4:0] addr,
                       input logic [63:0] data, input logic ena);
    bus.in_valid[ch]          = 1'b1;
    bus.in_pc[ch*64 +: 64]    = pc;
    bus.in_addr[ch*5 +: 5]    = addr;
    bus.in_data[ch*64 +: 64]  = data;
    bus.in_ena[ch]            = ena;
  endtask

  // ---------------- observation helpers ----------------
  function automatic logic [63:0] wb_d(input int ch);
    return bus.wb_data[ch*64 +: 64];
  endfunction

  function automatic logic [63:0] wb_p(input int ch);
    return bus.wb_pc[ch*64 +: 64];
  endfunction

  function automatic logic [63:0] wb_a(input int ch);
    return 64'(bus.wb_addr[ch*5 +: 5]);
  endfunction

  function automatic logic [63:0] occ(input int ch);
    return 64'(bus.occupancy[ch*3 +: 3]);
  endfunction

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a retirement on channel ch; returns edges taken.
  // in_valid is dropped after the first edge so only one entry is offered.
  task automatic wait_retire(input int ch, output int lat);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      bus.in_valid = '0;
      lat++;
      if (bus.wb_retire[ch]) break;
    end
  endtask

  // One edge, then scoreboard any retirement on channel 0.
  task automatic tick_chk0();
    tick();
    if (bus.wb_retire[0]) begin
      if (exp_q.size() == 0) check_eq("simul_extra_retire", 64'd1, 64'd0);
      else check_eq("simul_data", wb_d(0), exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;

    rst           = 1'b1;
    bus.commit_pc = '0;
    bus.flush     = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_addr   = '0;
    bus.in_pc     = '0;
    bus.in_ena    = '0;

    // 1. Reset
    repeat (2) tick();
    check_eq("rst_wb_data",   64'(bus.wb_data != '0), 64'd0);
    check_eq("rst_wb_addr",   64'(bus.wb_addr), 64'd0);
    check_eq("rst_wb_pc",     64'(bus.wb_pc != '0), 64'd0);
    check_eq("rst_wb_ena",    64'(bus.wb_ena), 64'd0);
    check_eq("rst_wb_retire", 64'(bus.wb_retire), 64'd0);
    check_eq("rst_occupancy", 64'(bus.occupancy), 64'd0);
    rst = 1'b0;
    check_eq("rst_in_ready",  64'(bus.in_ready), 64'h7);

    // 2. In-order retirement on ch0
    bus.commit_pc = 64'h8000_0000;
    offer(0, 64'h8000_0000, 5'd5, 64'h1234, 1'b1);
    wait_retire(0, lat);
    check_eq("inorder_latency", 64'(lat), 64'(EXP_LAT));
    check_eq("inorder_ena",  64'(bus.wb_ena[0]), 64'd1);
    check_eq("inorder_addr", wb_a(0), 64'd5);
    check_eq("inorder_data", wb_d(0), 64'h1234);
    check_eq("inorder_pc",   wb_p(0), 64'h8000_0000);
    tick();
    check_eq("inorder_ena_drop",  64'(bus.wb_ena[0]), 64'd0);
    check_eq("inorder_data_hold", wb_d(0), 64'h1234);

    // 3. Hold on ch1 until commit_pc catches up
    bus.commit_pc = 64'h8000_0004;
    offer(1, 64'h8000_0008, 5'd7, 64'hBEEF, 1'b1);
    tick();
    bus.in_valid = '0;
    tick();
    check_eq("hold_occ",    occ(1), 64'd1);
    check_eq("hold_ena",    64'(bus.wb_ena[1]), 64'd0);
    check_eq("hold_retire", 64'(bus.wb_retire[1]), 64'd0);
    bus.commit_pc = 64'h8000_0008;
    tick();
    check_eq("hold_release_retire", 64'(bus.wb_retire[1]), 64'd1);
    check_eq("hold_release_data",   wb_d(1), 64'hBEEF);
    check_eq("hold_release_addr",   wb_a(1), 64'd7);
    check_eq("hold_release_occ",    occ(1), 64'd0);

    // 4. Fill ch2, check full, drain in order, then a second round (wrap)
    bus.commit_pc = 64'h10;
    for (int k = 0; k < 4; k++) begin
      offer(2, 64'h1000 + 64'(4*k), 5'(k+1), 64'hA0 + 64'(k), 1'b1);
      exp_q.push_back(64'hA0 + 64'(k));
      tick();
    end
    check_eq("full_occ",   occ(2), 64'd4);
    check_eq("full_ready", 64'(bus.in_ready[2]), 64'd0);
    offer(2, 64'h2000, 5'd9, 64'hFF, 1'b1);   // held while full: not taken
    tick();
    check_eq("full_hold_occ", occ(2), 64'd4);
    bus.in_valid = '0;
    bus.commit_pc = 64'h2000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("drain_retire", 64'(bus.wb_retire[2]), 64'd1);
      check_eq("drain_data",   wb_d(2), exp_q.pop_front());
      check_eq("drain_pc",     wb_p(2), 64'h1000 + 64'(4*k));
    end
    check_eq("drain_ready", 64'(bus.in_ready[2]), 64'd1);
    check_eq("drain_occ",   occ(2), 64'd0);

    bus.commit_pc = 64'h10;
    for (int k = 0; k < 4; k++) begin
      offer(2, 64'h3000 + 64'(4*k), 5'(k+10), 64'hB0 + 64'(k), 1'b1);
      exp_q.push_back(64'hB0 + 64'(k));
      tick();
    end
    bus.in_valid = '0;
    check_eq("wrap_occ", occ(2), 64'd4);
    bus.commit_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("wrap_retire", 64'(bus.wb_retire[2]), 64'd1);
      check_eq("wrap_data",   wb_d(2), exp_q.pop_front());
      check_eq("wrap_addr",   wb_a(2), 64'(k+10));
    end
    tick();
    check_eq("wrap_idle_retire", 64'(bus.wb_retire[2]), 64'd0);

    // 5. x0 destination and ena=0 both retire without a write
    offer(0, 64'h100, 5'd0, 64'h55, 1'b1);
    wait_retire(0, lat);
    check_eq("x0_latency", 64'(lat), 64'(EXP_LAT));
    check_eq("x0_ena",     64'(bus.wb_ena[0]), 64'd0);
    check_eq("x0_data",    wb_d(0), 64'h55);
    offer(0, 64'h104, 5'd3, 64'h66, 1'b0);
    wait_retire(0, lat);
    check_eq("noena_latency", 64'(lat), 64'(EXP_LAT));
    check_eq("noena_ena",     64'(bus.wb_ena[0]), 64'd0);
    check_eq("noena_addr",    wb_a(0), 64'd3);

    // Back-to-back entries on ch0 with commit_pc open: accept and retire overlap
    exp_q = {};
    for (int k = 0; k < 3; k++) begin
      offer(0, 64'h200 + 64'(4*k), 5'(k+1), 64'hC0 + 64'(k), 1'b1);
      exp_q.push_back(64'hC0 + 64'(k));
      tick_chk0();
    end
    bus.in_valid = '0;
    for (int k = 0; k < 4; k++) tick_chk0();
    check_eq("simul_drained", 64'(exp_q.size()), 64'd0);
    check_eq("simul_occ",     occ(0), 64'd0);

    // 6. Flush with 3 entries buffered on ch1 and a new one offered
    bus.commit_pc = 64'h10;
    for (int k = 0; k < 3; k++) begin
      offer(1, 64'h500 + 64'(4*k), 5'(k+1), 64'hD0 + 64'(k), 1'b1);
      tick();
    end
    check_eq("flush_pre_occ", occ(1), 64'd3);
    offer(1, 64'h8, 5'd4, 64'hDEAD, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    check_eq("flush_occ",       64'(bus.occupancy), 64'd0);
    check_eq("flush_wb_ena",    64'(bus.wb_ena), 64'd0);
    check_eq("flush_wb_retire", 64'(bus.wb_retire), 64'd0);
    check_eq("flush_data_hold", wb_d(1), 64'hBEEF);
    bus.commit_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) tick();
    check_eq("flush_no_late_retire", 64'(bus.wb_retire[1]), 64'd0);

    // Reset mid-operation clears buffered entries and wb fields
    bus.commit_pc = 64'h10;
    offer(2, 64'h900, 5'd2, 64'h77, 1'b1);
    tick();
    bus.in_valid = '0;
    check_eq("midrst_pre_occ", occ(2), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_occ",     64'(bus.occupancy), 64'd0);
    check_eq("midrst_wb_data", 64'(bus.wb_data != '0), 64'd0);
    check_eq("midrst_wb_pc",   64'(bus.wb_pc != '0), 64'd0);
    check_eq("midrst_wb_addr", 64'(bus.wb_addr), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
